// File: rtl/obstacle_spawn_scheduler.sv
// obstacle_spawn_scheduler
//   Decides when each of the three obstacle slots is released onto the screen and which sprite
//   type it carries. A free-running 16-bit Galois LFSR supplies the random gap extension and the
//   sprite type. The base gap shrinks every 8 releases down to a floor.
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   frame_tick_i   one-clk pulse per video frame
//   game_state_i   0=READY, 1=RUNNING, 2/3=OVER
//   slot_done_i    per-slot pulse: obstacle has left the screen
//   release_o      one-clk pulse: start moving slot i from the right edge
//   obsN_sel_o     sprite type of slot N, held between releases
//   active_o       slot i in flight
//   spawn_count_o  releases since the last restart, saturating
module obstacle_spawn_scheduler #(
    parameter int unsigned MIN_GAP   = 40,
    parameter int unsigned GAP_BITS  = 6,
    parameter int unsigned GAP_FLOOR = 16,
    parameter int unsigned GAP_STEP  = 2,
    parameter int unsigned FIRST_GAP = 30,
    parameter int unsigned NUM_TYPES = 6,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        frame_tick_i,
    input  logic [1:0]  game_state_i,
    input  logic [2:0]  slot_done_i,
    output logic [2:0]  release_o,
    output logic [3:0]  obs1_sel_o,
    output logic [3:0]  obs2_sel_o,
    output logic [3:0]  obs3_sel_o,
    output logic [2:0]  active_o,
    output logic [15:0] spawn_count_o
);

    localparam logic [7:0] MinGapW   = 8'(MIN_GAP);
    localparam logic [7:0] FirstGapW = 8'(FIRST_GAP);
    localparam logic [7:0] GapFloorW = 8'(GAP_FLOOR);
    localparam logic [7:0] GapStepW  = 8'(GAP_STEP);
    localparam logic [3:0] NumTypesW = 4'(NUM_TYPES);

    localparam logic [1:0] GsReady   = 2'd0;
    localparam logic [1:0] GsRunning = 2'd1;

    typedef enum logic [1:0] {StStop, StWait, StFull, StRelease} state_e;

    state_e            state_q, state_d;
    logic [2:0]        release_q, release_d;
    logic [2:0]        active_q, active_d;
    logic [2:0][3:0]   sel_q, sel_d;
    logic [15:0]       spawn_count_q, spawn_count_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic [7:0]        gap_base_q, gap_base_d;
    logic [15:0]       lfsr_q, lfsr_d;

    logic [2:0]        free_slot;
    logic              any_free;
    logic [3:0]        type_raw;
    logic [3:0]        type_sel;
    logic [15:0]       count_inc;
    logic [7:0]        base_next;
    logic [7:0]        gap_ext;
    logic              do_release;

    always_comb begin
        // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

        // Lowest-index free slot, one-hot; zero when all slots are in flight.
        free_slot = 3'b000;
        if (!active_q[0]) begin
            free_slot = 3'b001;
        end else if (!active_q[1]) begin
            free_slot = 3'b010;
        end else if (!active_q[2]) begin
            free_slot = 3'b100;
        end
        any_free = ~&active_q;

        type_raw = {1'b0, lfsr_q[14:12]};
        type_sel = (type_raw < NumTypesW) ? type_raw : type_raw - NumTypesW;

        count_inc = (spawn_count_q == 16'hFFFF) ? spawn_count_q : spawn_count_q + 16'd1;

        // Ramp is applied before the reload so the new base governs the very next gap.
        base_next = gap_base_q;
        if (count_inc[2:0] == 3'd0) begin
            base_next = (gap_base_q >= GapFloorW + GapStepW) ? gap_base_q - GapStepW : GapFloorW;
        end
        gap_ext = 8'(lfsr_q[GAP_BITS-1:0]);
    end

    always_comb begin
        state_d       = state_q;
        release_d     = 3'b000;
        active_d      = active_q & ~slot_done_i;
        sel_d         = sel_q;
        spawn_count_d = spawn_count_q;
        gap_cnt_d     = gap_cnt_q;
        gap_base_d    = gap_base_q;
        do_release    = 1'b0;

        unique case (state_q)
            StStop: begin
                if (game_state_i == GsReady) begin
                    active_d      = 3'b000;
                    spawn_count_d = 16'd0;
                    gap_base_d    = MinGapW;
                    gap_cnt_d     = FirstGapW;
                end else if (game_state_i == GsRunning) begin
                    state_d = StWait;
                end else begin
                    // Game over: everything frozen, slot_done ignored.
                    active_d = active_q;
                end
            end
            StWait: begin
                if (game_state_i != GsRunning) begin
                    state_d = StStop;
                end else if (frame_tick_i) begin
                    if (gap_cnt_q != 8'd0) begin
                        gap_cnt_d = gap_cnt_q - 8'd1;
                    end
                    if (gap_cnt_q <= 8'd1) begin
                        if (any_free) begin
                            do_release = 1'b1;
                        end else begin
                            state_d = StFull;
                        end
                    end
                end
            end
            StFull: begin
                if (game_state_i != GsRunning) begin
                    state_d = StStop;
                end else if (any_free) begin
                    do_release = 1'b1;
                end
            end
            StRelease: begin
                state_d = (game_state_i == GsRunning) ? StWait : StStop;
            end
            default: state_d = StStop;
        endcase

        // Release side effects are registered on the edge entering StRelease, so the pulse,
        // the new sel and the active bit are all visible during the single StRelease cycle.
        if (do_release) begin
            state_d       = StRelease;
            release_d     = free_slot;
            active_d      = (active_q & ~slot_done_i) | free_slot;
            spawn_count_d = count_inc;
            gap_base_d    = base_next;
            gap_cnt_d     = base_next + gap_ext;
            for (int i = 0; i < 3; i++) begin
                if (free_slot[i]) begin
                    sel_d[i] = type_sel;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StStop;
            release_q     <= 3'b000;
            active_q      <= 3'b000;
            sel_q         <= '0;
            spawn_count_q <= 16'd0;
            gap_cnt_q     <= 8'd0;
            gap_base_q    <= MinGapW;
            lfsr_q        <= SEED;
        end else begin
            state_q       <= state_d;
            release_q     <= release_d;
            active_q      <= active_d;
            sel_q         <= sel_d;
            spawn_count_q <= spawn_count_d;
            gap_cnt_q     <= gap_cnt_d;
            gap_base_q    <= gap_base_d;
            lfsr_q        <= lfsr_d;
        end
    end

    assign release_o     = release_q;
    assign active_o      = active_q;
    assign obs1_sel_o    = sel_q[0];
    assign obs2_sel_o    = sel_q[1];
    assign obs3_sel_o    = sel_q[2];
    assign spawn_count_o = spawn_count_q;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Testbench for obstacle_spawn_scheduler: directed vector table, hand-written multi-cycle
// sequences (fill/full/ramp/async reset) and a long randomized run against a behavioural model.
module tb_obstacle_spawn_scheduler;

    localparam int MinGap   = 40;
    localparam int GapFloor = 16;
    localparam int GapStep  = 2;
    localparam int FirstGap = 30;
    localparam int NumTypes = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [1:0]  game_state;
    logic [2:0]  slot_done;
    logic [2:0]  release_o;
    logic [3:0]  obs1_sel_o, obs2_sel_o, obs3_sel_o;
    logic [2:0]  active_o;
    logic [15:0] spawn_count_o;

    obstacle_spawn_scheduler dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .frame_tick_i  (frame_tick),
        .game_state_i  (game_state),
        .slot_done_i   (slot_done),
        .release_o     (release_o),
        .obs1_sel_o    (obs1_sel_o),
        .obs2_sel_o    (obs2_sel_o),
        .obs3_sel_o    (obs3_sel_o),
        .active_o      (active_o),
        .spawn_count_o (spawn_count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_checks++;
        if (val >= lo && val <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the game at the level of "ticks still owed before the next release", whether a
    // release is owed but blocked by full slots, and whether we are in a game at all.
    logic [15:0] m_lfsr;
    logic        m_run, m_inrel, m_blocked;
    logic [2:0]  m_active, m_rel;
    logic [15:0] m_count;
    int          m_base, m_remain;
    logic [3:0]  m_sel [3];

    function automatic logic [3:0] type_of(input logic [15:0] l);
        int v;
        v = int'(l[14:12]);
        return (v < NumTypes) ? 4'(v) : 4'(v - NumTypes);
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1; m_run = 0; m_inrel = 0; m_blocked = 0;
        m_active = 0; m_rel = 0; m_count = 0; m_base = MinGap; m_remain = 0;
        for (int i = 0; i < 3; i++) m_sel[i] = 4'd0;
    endtask

    task automatic model_edge(input logic [1:0] g, input logic t, input logic [2:0] d);
        bit go;
        int idx;
        go = 0;
        m_rel = 3'b000;
        if (!m_run) begin
            if (g == 2'd0) begin
                m_active = 0; m_count = 0; m_base = MinGap; m_remain = FirstGap;
            end else if (g == 2'd1) begin
                m_run = 1; m_active &= ~d;
            end
        end else if (m_inrel) begin
            m_inrel = 0; m_active &= ~d;
            if (g != 2'd1) m_run = 0;
        end else if (g != 2'd1) begin
            m_run = 0; m_blocked = 0; m_active &= ~d;
        end else if (m_blocked) begin
            if (m_active != 3'b111) go = 1;
            else m_active &= ~d;
        end else begin
            if (t) begin
                if (m_remain <= 1) begin
                    if (m_active != 3'b111) go = 1;
                    else m_blocked = 1;
                end
                if (m_remain > 0) m_remain--;
            end
            if (!go) m_active &= ~d;
        end
        if (go) begin
            idx = 0;
            while (m_active[idx]) idx++;
            m_rel = 3'b000;
            m_rel[idx] = 1'b1;
            m_active = (m_active & ~d) | m_rel;
            if (m_count != 16'hFFFF) m_count++;
            if (m_count[2:0] == 3'd0) m_base = (m_base - GapStep < GapFloor) ? GapFloor
                                                                              : m_base - GapStep;
            m_remain = m_base + int'(m_lfsr[5:0]);
            m_sel[idx] = type_of(m_lfsr);
            m_inrel = 1; m_blocked = 0;
        end
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare everything.
    task automatic cyc(input logic [1:0] g, input logic t, input logic [2:0] d);
        game_state = g; frame_tick = t; slot_done = d;
        @(posedge clk);
        #1;
        model_edge(g, t, d);
        check("model", {release_o, active_o, spawn_count_o, obs1_sel_o, obs2_sel_o, obs3_sel_o,
                        dut.lfsr_q},
              {m_rel, m_active, m_count, m_sel[0], m_sel[1], m_sel[2], m_lfsr});
    endtask

    // Frees the slots in free_mask during the first (tick-free) cycle, then ticks every cycle
    // until a release appears; nt is the number of ticks it took.
    task automatic run_to_release(input logic [2:0] free_mask, output int nt,
                                  output logic [2:0] r);
        bit found;
        found = 0; nt = 0; r = 3'b000;
        cyc(2'd1, 1'b0, free_mask);
        for (int i = 0; i < 400 && !found; i++) begin
            cyc(2'd1, 1'b1, 3'b000);
            nt++;
            if (release_o != 3'b000) begin
                found = 1; r = release_o;
            end
        end
        check("release_seen", 64'(found), 64'd1);
    endtask

    function automatic int base_for(input int k);
        int b;
        b = MinGap - GapStep * (k / 8);
        return (b < GapFloor) ? GapFloor : b;
    endfunction

    typedef struct {
        logic [1:0]  gs;
        logic        tick;
        logic [2:0]  done;
        int          reps;
        logic [2:0]  rel;
        logic [2:0]  act;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int          nt, k;
        logic [2:0]  r;
        bit          seen;
        logic [2:0]  exp_slot [3];

        tbl[0]  = '{2'd0, 1'b0, 3'b000,   5, 3'b000, 3'b000, 16'd0};
        tbl[1]  = '{2'd1, 1'b0, 3'b000,   1, 3'b000, 3'b000, 16'd0};
        tbl[2]  = '{2'd1, 1'b1, 3'b000,  29, 3'b000, 3'b000, 16'd0};
        tbl[3]  = '{2'd1, 1'b1, 3'b000,   1, 3'b001, 3'b001, 16'd1};
        tbl[4]  = '{2'd1, 1'b0, 3'b000,   1, 3'b000, 3'b001, 16'd1};
        tbl[5]  = '{2'd1, 1'b0, 3'b100,   1, 3'b000, 3'b001, 16'd1};
        tbl[6]  = '{2'd1, 1'b1, 3'b000,  10, 3'b000, 3'b001, 16'd1};
        tbl[7]  = '{2'd2, 1'b0, 3'b000,   1, 3'b000, 3'b001, 16'd1};
        tbl[8]  = '{2'd3, 1'b1, 3'b000, 100, 3'b000, 3'b001, 16'd1};
        tbl[9]  = '{2'd2, 1'b0, 3'b001,   1, 3'b000, 3'b001, 16'd1};
        tbl[10] = '{2'd0, 1'b0, 3'b000,   1, 3'b000, 3'b000, 16'd0};
        tbl[11] = '{2'd1, 1'b0, 3'b000,   1, 3'b000, 3'b000, 16'd0};
        tbl[12] = '{2'd1, 1'b1, 3'b000,  29, 3'b000, 3'b000, 16'd0};
        tbl[13] = '{2'd1, 1'b1, 3'b000,   1, 3'b001, 3'b001, 16'd1};
        tbl[14] = '{2'd1, 1'b0, 3'b001,   1, 3'b000, 3'b000, 16'd1};

        exp_slot[0] = 3'b001; exp_slot[1] = 3'b010; exp_slot[2] = 3'b100;

        rst = 1'b1; frame_tick = 1'b0; game_state = 2'd0; slot_done = 3'b000;
        model_reset();
        #12;
        rst = 1'b0;

        check("reset_release", 64'(release_o), 64'd0);
        check("reset_active", 64'(active_o), 64'd0);
        check("reset_count", 64'(spawn_count_o), 64'd0);
        check("reset_sels", {obs1_sel_o, obs2_sel_o, obs3_sel_o}, 64'd0);
        check("reset_lfsr", 64'(dut.lfsr_q), 64'hACE1);

        for (int i = 0; i < 15; i++) begin
            for (int n = 0; n < tbl[i].reps; n++) cyc(tbl[i].gs, tbl[i].tick, tbl[i].done);
            check($sformatf("vec%0d_release", i), 64'(release_o), 64'(tbl[i].rel));
            check($sformatf("vec%0d_active", i), 64'(active_o), 64'(tbl[i].act));
            check($sformatf("vec%0d_count", i), 64'(spawn_count_o), 64'(tbl[i].cnt));
        end
        check_range("first_sel_type", int'(obs1_sel_o), 0, NumTypes - 1);

        // Fill all three slots in order, checking each gap against the base-gap window.
        k = 1;
        for (int s = 0; s < 3; s++) begin
            run_to_release(3'b000, nt, r);
            check_range($sformatf("fill_gap%0d", s), nt, base_for(k), base_for(k) + 63);
            k++;
            check($sformatf("fill_release%0d", s), 64'(r), 64'(exp_slot[s]));
            check($sformatf("fill_count%0d", s), 64'(spawn_count_o), 64'(k));
        end
        check("fill_active", 64'(active_o), 64'b111);

        // All slots busy: many ticks must produce nothing.
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(2'd1, 1'b1, 3'b000);
            if (release_o != 3'b000) seen = 1;
        end
        check("full_no_release", 64'(seen), 64'd0);
        check("full_active", 64'(active_o), 64'b111);

        // Freeing slot 1 releases it exactly two clocks after the done pulse.
        cyc(2'd1, 1'b0, 3'b010);
        check("full_done_active", 64'(active_o), 64'b101);
        check("full_done_release0", 64'(release_o), 64'd0);
        cyc(2'd1, 1'b0, 3'b000);
        check("full_done_release", 64'(release_o), 64'b010);
        check("full_done_active2", 64'(active_o), 64'b111);
        k++;

        // Difficulty ramp down to the floor: keep recycling slot 1.
        while (k < 100) begin
            run_to_release(3'b010, nt, r);
            check_range($sformatf("ramp_gap_k%0d", k), nt, base_for(k), base_for(k) + 63);
            k++;
            check($sformatf("ramp_release_k%0d", k), 64'(r), 64'b010);
            check($sformatf("ramp_count_k%0d", k), 64'(spawn_count_o), 64'(k));
        end

        // Asynchronous reset in the middle of the release cycle.
        #1 rst = 1'b1;
        #1;
        check("areset_release", 64'(release_o), 64'd0);
        check("areset_active", 64'(active_o), 64'd0);
        check("areset_count", 64'(spawn_count_o), 64'd0);
        check("areset_sels", {obs1_sel_o, obs2_sel_o, obs3_sel_o}, 64'd0);
        check("areset_lfsr", 64'(dut.lfsr_q), 64'hACE1);
        #1 rst = 1'b0;
        model_reset();

        // Long randomized run against the model.
        game_state = 2'd1;
        for (int c = 0; c < 40000 && (n_checks - n_pass) < 20; c++) begin
            logic [1:0] g;
            logic       t;
            logic [2:0] d;
            int         pr;
            g = game_state;
            if ($urandom_range(0, 2999) == 0) begin
                case ($urandom_range(0, 7))
                    0:       g = 2'd0;
                    1:       g = 2'd2;
                    2:       g = 2'd3;
                    default: g = 2'd1;
                endcase
            end else if (g != 2'd1 && $urandom_range(0, 49) == 0) begin
                g = 2'd1;
            end
            t = ($urandom_range(0, 3) == 0);
            pr = ((c / 4000) % 2 == 1) ? 40 : 1500;
            for (int b = 0; b < 3; b++) d[b] = ($urandom_range(0, pr - 1) == 0);
            cyc(g, t, d);
        end
        check("lfsr_nonzero", 64'(dut.lfsr_q != 16'h0000), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
